// File: rtl/log_lane_mover.sv
// Purpose : pool of river-log slots; seeds X from the offset table, moves each slot once per frame, retires/respawns.
// Latency : LOAD takes NUM_SLOTS cycles; a frame pass writes slot s at s+1 cycles after startOfFrame, frame_done right after.
// Backpressure: none; startOfFrame seen outside RUN (or while paused) is dropped, start=0 aborts to IDLE.
// Ports   : CLK/reset (sync, active-high); start/startOfFrame/pause control; start_offsetX/Y packed 9-bit table;
//           logX (signed 11b per slot), logY (10b per slot, constant), log_active, busy, frame_done (all registered).
module log_lane_mover #(
    parameter int NUM_SLOTS  = 8,
    parameter int NUM_LANES  = 4,
    parameter int TABLE_SIZE = 100,
    parameter int SCREEN_W   = 640,
    parameter int LOG_W      = 96,
    parameter int LANE_Y0    = 64,
    parameter int LANE_H     = 32
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      startOfFrame,
    input  logic                      pause,
    input  logic [9*TABLE_SIZE-1:0]   start_offsetX,
    input  logic [9*TABLE_SIZE-1:0]   start_offsetY,
    output logic [11*NUM_SLOTS-1:0]   logX,
    output logic [10*NUM_SLOTS-1:0]   logY,
    output logic [NUM_SLOTS-1:0]      log_active,
    output logic                      busy,
    output logic                      frame_done
);

    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic signed [10:0] RIGHT_EDGE = 11'(SCREEN_W);
    localparam logic signed [10:0] LEFT_EDGE  = 11'(-LOG_W);

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, UPDATE = 2'd3} state_t;

    // Unpack the table; only the low 6 bits of a Y entry seed the respawn delay.
    logic [8:0]              tab_x [TABLE_SIZE];
    logic [5:0]              tab_y [TABLE_SIZE];
    logic [3*TABLE_SIZE-1:0] unused_y_hi;

    for (genvar gi = 0; gi < TABLE_SIZE; gi++) begin : g_tab
        assign tab_x[gi]             = start_offsetX[gi*9 +: 9];
        assign tab_y[gi]             = start_offsetY[gi*9 +: 6];
        assign unused_y_hi[gi*3 +: 3] = start_offsetY[gi*9+6 +: 3];
    end

    state_t                 state_q, state_d;
    logic [SW-1:0]          slot_q, slot_d;
    logic [6:0]             ptr_q, ptr_d;
    logic signed [10:0]     x_q [NUM_SLOTS];
    logic signed [10:0]     x_d [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]   act_q, act_d;
    logic [6:0]             wait_q [NUM_SLOTS];
    logic [6:0]             wait_d [NUM_SLOTS];
    logic                   busy_q, busy_d;
    logic                   frame_done_q, frame_done_d;

    logic                   last_slot;
    int                     lane;
    logic                   right;
    logic signed [10:0]     spd, cur_x, nx;
    logic [6:0]             cur_w, ptr_next;
    logic                   retire;

    assign last_slot = (slot_q == SW'(NUM_SLOTS - 1));
    assign ptr_next  = (ptr_q == 7'(TABLE_SIZE - 1)) ? 7'd0 : ptr_q + 7'd1;

    // State register (plus datapath flops)
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q      <= IDLE;
            slot_q       <= '0;
            ptr_q        <= '0;
            act_q        <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            for (int k = 0; k < NUM_SLOTS; k++) begin
                x_q[k]    <= '0;
                wait_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            ptr_q        <= ptr_d;
            act_q        <= act_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            for (int k = 0; k < NUM_SLOTS; k++) begin
                x_q[k]    <= x_d[k];
                wait_q[k] <= wait_d[k];
            end
        end
    end

    // Next-state logic; dropping start wins over everything.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    if (last_slot) state_d = RUN;
            RUN:     if (startOfFrame && !pause) state_d = UPDATE;
            UPDATE:  if (last_slot) state_d = RUN;
            default: state_d = IDLE;
        endcase
        if (!start) state_d = IDLE;
    end

    // Per-slot datapath; only the slot selected by slot_q is touched each cycle.
    always_comb begin
        lane   = int'(slot_q) % NUM_LANES;
        right  = (lane % 2) == 0;
        spd    = 11'(lane + 1);
        cur_x  = x_q[slot_q];
        cur_w  = wait_q[slot_q];
        nx     = right ? (cur_x + spd) : (cur_x - spd);
        retire = right ? (nx >= RIGHT_EDGE) : (nx <= LEFT_EDGE);

        slot_d       = slot_q;
        ptr_d        = ptr_q;
        act_d        = act_q;
        frame_done_d = 1'b0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            x_d[k]    = x_q[k];
            wait_d[k] = wait_q[k];
        end

        case (state_q)
            LOAD: begin
                x_d[slot_q]    = {2'b00, tab_x[ptr_q]};
                act_d[slot_q]  = 1'b1;
                wait_d[slot_q] = '0;
                ptr_d          = ptr_next;
                slot_d         = last_slot ? '0 : slot_q + 1'b1;
            end
            UPDATE: begin
                if (act_q[slot_q]) begin
                    if (retire) begin
                        // X is left at its last on-screen value.
                        act_d[slot_q]  = 1'b0;
                        wait_d[slot_q] = {1'b0, tab_y[ptr_q]} + 7'd1;
                        ptr_d          = ptr_next;
                    end else begin
                        x_d[slot_q] = nx;
                    end
                end else if (cur_w <= 7'd1) begin
                    // Delay expired: re-enter from the off-screen side of the lane.
                    act_d[slot_q]  = 1'b1;
                    wait_d[slot_q] = '0;
                    x_d[slot_q]    = right ? LEFT_EDGE : RIGHT_EDGE;
                end else begin
                    wait_d[slot_q] = cur_w - 7'd1;
                end
                slot_d       = last_slot ? '0 : slot_q + 1'b1;
                frame_done_d = last_slot;
            end
            default: slot_d = '0;
        endcase

        if (!start) begin
            slot_d = '0;
            ptr_d  = '0;
            act_d  = '0;
            for (int k = 0; k < NUM_SLOTS; k++) begin
                x_d[k]    = '0;
                wait_d[k] = '0;
            end
        end

        busy_d = (state_d == LOAD) || (state_d == UPDATE);
    end

    // Outputs come straight from flops.
    for (genvar gk = 0; gk < NUM_SLOTS; gk++) begin : g_out
        assign logX[gk*11 +: 11] = x_q[gk];
        assign logY[gk*10 +: 10] = 10'(LANE_Y0 + (gk % NUM_LANES) * LANE_H);
    end
    assign log_active = act_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: doc/log_lane_mover.md
# log_lane_mover

Downstream consumer of the static random offset table. Holds a small pool of active log slots in fixed river lanes. Seeds each slot's start position from the 100-entry X/Y offset table, then advances every slot once per video frame with per-lane speed and direction. When a log leaves the screen, its slot is retired and respawned after a table-derived frame delay. Outputs feed the log drawing and frog-on-log collision blocks.

## Interface

**Parameters**
- NUM_SLOTS, 8: number of log slots; slot k is in lane k % NUM_LANES.
- NUM_LANES, 4: river lanes; even lanes move right, odd lanes move left.
- TABLE_SIZE, 100: depth of the offset table.
- SCREEN_W, 640: visible width in pixels.
- LOG_W, 96: log width in pixels.
- LANE_Y0, 64: top Y of lane 0.
- LANE_H, 32: lane pitch in pixels.

**Ports**
- CLK: in, 1. System clock.
- reset: in, 1. Synchronous, active-high.
- start: in, 1. Level; game running.
- startOfFrame: in, 1. One-cycle pulse per video frame.
- pause: in, 1. Level; suppresses movement.
- start_offsetX: in, 9 × TABLE_SIZE. Table X entries.
- start_offsetY: in, 9 × TABLE_SIZE. Table Y entries; used as delay seeds.
- logX: out, signed 11 × NUM_SLOTS. Slot left edge in pixels.
- logY: out, 10 × NUM_SLOTS. Slot top edge; equals LANE_Y0 + lane·LANE_H.
- log_active: out, NUM_SLOTS. Slot visible.
- busy: out, 1. High in LOAD or UPDATE.
- frame_done: out, 1. One-cycle pulse at the end of each UPDATE pass.

## Operation

**States:** IDLE, LOAD, RUN, UPDATE.

**IDLE**
- logX = 0, log_active = 0, table pointer ptr = 0.
- start = 1 → LOAD with slot index s = 0.

**LOAD** (one slot per cycle, NUM_SLOTS cycles)
- logX[s] = zero-extended start_offsetX[ptr] (range 0..511).
- log_active[s] = 1, wait[s] = 0.
- ptr = ptr + 1, wrapping TABLE_SIZE-1 → 0.
- After the last slot → RUN.

**RUN**
- startOfFrame && !pause → UPDATE with s = 0.

**UPDATE** (one slot per cycle). Lane L = s % NUM_LANES, speed = L + 1 px/frame.
- **Active, right-moving:** X' = X + speed. If X' ≥ SCREEN_W, retire the slot.
- **Active, left-moving:** X' = X − speed. If X' ≤ −LOG_W, retire the slot.
- **Retire:** log_active = 0, wait = start_offsetY[ptr][5:0] + 1, ptr advances (wrapping). logX holds its last in-screen value.
- **Inactive:**
  - wait decrements.
  - If wait reaches 0, respawn: log_active = 1, logX = −LOG_W for right lanes or SCREEN_W for left lanes. No table read on respawn.
- After slot NUM_SLOTS−1: frame_done pulses and the FSM returns to RUN.

**Arithmetic and ordering**
- All X math is 11-bit signed.
- ptr is 7-bit and wraps modulo TABLE_SIZE.
- Table reads happen only on LOAD and retire, in strict slot order.

**Global rules**
- start = 0 in any state → IDLE on the next cycle, clearing log_active. An in-progress LOAD or UPDATE is abandoned.
- startOfFrame arriving in LOAD or UPDATE is dropped, not queued.
- pause does not interrupt an UPDATE already begun.

## Timing

- **Reset:** every output is 0 (logX, log_active, busy, frame_done). logY is constant per slot, from parameters. State is IDLE, ptr = 0, all wait = 0.
- **Reset mid-operation:** same values on the cycle after reset is sampled. Reset beats start.
- **LOAD:** NUM_SLOTS cycles. busy is high from the cycle after start is sampled until RUN is entered.
- **UPDATE:** slot s is written s+1 cycles after the startOfFrame sample. frame_done is high the cycle after the last slot is written. Total is NUM_SLOTS+1 cycles from pulse to frame_done.
- **Output timing:** all outputs are registered. No combinational path from inputs to outputs.

## Test plan

- **Reset:** reset = 1 for 3 cycles with start = 1 → all logX = 0, log_active = 0, busy = 0. logY[1] = 96, logY[3] = 160.
- **Load:** start_offsetX[0..7] = 496, 133, 5, 254, 0, 511, 320, 64; start = 1 → after 8 cycles, logX equals those values, log_active = 8'hFF, busy falls, ptr = 8.
- **Single frame:** one startOfFrame → logX[0] = 497, logX[1] = 131, logX[2] = 8, logX[3] = 250. frame_done pulses 9 cycles after the pulse.
- **Right-lane retire and respawn:**
  - Setup: slot 0 at X = 639, start_offsetY[8] = 9'b000000010.
  - Frame 1: log_active[0] = 0, wait = 3.
  - Frame 4: log_active[0] = 1, logX[0] = −96.
  - Frame 5: logX[0] = −95.
- **Left-lane retire and ptr wrap:**
  - Setup: slot 1 at X = −95, ptr = 99.
  - Expected: slot 1 retires using start_offsetY[99], and ptr becomes 0.
- **Pause and drop rules:**
  - pause = 1 for 5 startOfFrame pulses → no logX change, no frame_done.
  - startOfFrame during UPDATE → ignored, exactly one frame_done.
  - start = 0 mid-UPDATE → IDLE next cycle with log_active = 0.
